// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: W add/shift iterations per operation,
// start/ready/done handshake shared with the restoring divider.
module shift_add_mult #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   mcand,
   input  logic [W-1:0]   mplier,
   output logic           ready,
   output logic           done,
   output logic [2*W-1:0] prod
);

   localparam int            NW     = $clog2(W + 1);
   localparam logic [NW-1:0] N_LOAD = NW'(W);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OP   = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_next;
   logic [W-1:0]   r_d;
   logic [W-1:0]   r_lo;
   logic [W:0]     r_hi;
   logic [NW-1:0]  r_n;
   logic [W:0]     w_addend;
   logic [W:0]     w_sum;
   logic           w_load;
   logic           w_shift;

   // One extra bit on the partial sum holds the carry; hi + d never exceeds W+1 bits.
   assign w_addend = r_lo[0] ? {1'b0, r_d} : '0;
   assign w_sum    = r_hi + w_addend;

   // NOTE: every output of this block gets a default before the case, so no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      ready        = 1'b0;
      done         = 1'b0;
      w_load       = 1'b0;
      w_shift      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) begin
               w_load       = 1'b1;
               w_state_next = S_OP;
            end
         end
         S_OP: begin
            w_shift = 1'b1;
            // Count reaches zero after this shift.
            if (r_n == NW'(1)) w_state_next = S_DONE;
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // NOTE: rst_n is synchronous, so it is tested only inside the clocked blocks; state uses <= throughout.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_d  <= '0;
         r_lo <= '0;
         r_hi <= '0;
         r_n  <= '0;
      end else if (w_load) begin
         r_d  <= mcand;
         r_lo <= mplier;
         r_hi <= '0;
         r_n  <= N_LOAD;
      end else if (w_shift) begin
         // {hi, lo} <= {0, sum, lo} >> 1 : sum LSB moves into the top of lo.
         r_hi <= {1'b0, w_sum[W:1]};
         r_lo <= {w_sum[0], r_lo[W-1:1]};
         r_n  <= r_n - NW'(1);
      end
   end

   assign prod = {r_hi[W-1:0], r_lo};

endmodule
